// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - issue, writeback, query and commit bundle of the reorder buffer
interface reorder_buffer_if #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
);
  logic                 issue_valid;
  logic [REG_WIDTH-1:0] issue_reg_id;
  logic                 issue_is_branch;
  logic [31:0]          issue_alt_pc;
  logic [ROB_WIDTH-1:0] issue_rob_id;
  logic                 full;

  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_rob_id;
  logic [31:0]          wb_data;
  logic                 wb_mispredict;

  logic [ROB_WIDTH-1:0] rob_rob_id_j;
  logic [ROB_WIDTH-1:0] rob_rob_id_k;
  logic                 rob_ready_j;
  logic                 rob_ready_k;
  logic [31:0]          rob_data_j;
  logic [31:0]          rob_data_k;

  logic [REG_WIDTH-1:0] commit_reg_id;
  logic [31:0]          commit_data;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic                 flush;
  logic [31:0]          flush_pc;

  modport master (
    output issue_valid, issue_reg_id, issue_is_branch, issue_alt_pc,
    output wb_valid, wb_rob_id, wb_data, wb_mispredict,
    output rob_rob_id_j, rob_rob_id_k,
    input  issue_rob_id, full, rob_ready_j, rob_ready_k, rob_data_j, rob_data_k,
    input  commit_reg_id, commit_data, commit_rob_id, flush, flush_pc
  );

  modport slave (
    input  issue_valid, issue_reg_id, issue_is_branch, issue_alt_pc,
    input  wb_valid, wb_rob_id, wb_data, wb_mispredict,
    input  rob_rob_id_j, rob_rob_id_k,
    output issue_rob_id, full, rob_ready_j, rob_ready_k, rob_data_j, rob_data_k,
    output commit_reg_id, commit_data, commit_rob_id, flush, flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order retirement queue with CDB writeback, queries and flush
// Optional ROB_BYPASS_EN: register-file queries also forward the same-cycle CDB result.
module reorder_buffer #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  reorder_buffer_if.slave bus
);
  localparam int                    ROB_SIZE = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0]    CNT_FULL = (ROB_WIDTH+1)'(ROB_SIZE);
  localparam logic [ROB_WIDTH:0]    CNT_ONE  = (ROB_WIDTH+1)'(1);
  localparam logic [ROB_WIDTH-1:0]  PTR_ONE  = ROB_WIDTH'(1);

  logic [ROB_SIZE-1:0]  valid_q;
  logic [ROB_SIZE-1:0]  ready_q;
  logic [ROB_SIZE-1:0]  is_branch_q;
  logic [ROB_SIZE-1:0]  mispredict_q;
  logic [REG_WIDTH-1:0] reg_id_q [ROB_SIZE];
  logic [31:0]          data_q   [ROB_SIZE];
  logic [31:0]          alt_pc_q [ROB_SIZE];

  logic [ROB_WIDTH-1:0] head_q;
  logic [ROB_WIDTH-1:0] tail_q;
  logic [ROB_WIDTH:0]   count_q;

  logic [REG_WIDTH-1:0] commit_reg_id_q;
  logic [31:0]          commit_data_q;
  logic [ROB_WIDTH-1:0] commit_rob_id_q;
  logic                 flush_q;
  logic [31:0]          flush_pc_q;

  logic full;
  logic alloc;
  logic wb_en;
  logic retire;
  logic do_flush;

  // Retire looks only at stored ready, so a same-edge writeback retires one edge later.
  assign full     = (count_q == CNT_FULL);
  assign alloc    = bus.issue_valid && !full && !flush_q;
  assign wb_en    = bus.wb_valid && !flush_q && valid_q[bus.wb_rob_id];
  assign retire   = !flush_q && (count_q != '0) && ready_q[head_q];
  assign do_flush = retire && is_branch_q[head_q] && mispredict_q[head_q];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q         <= '0;
      ready_q         <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      commit_reg_id_q <= '0;
      commit_data_q   <= '0;
      commit_rob_id_q <= '0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
    end else if (rdy_in) begin
      flush_q <= do_flush;
      if (do_flush) begin
        valid_q         <= '0;
        ready_q         <= '0;
        head_q          <= '0;
        tail_q          <= '0;
        count_q         <= '0;
        commit_reg_id_q <= '0;
        flush_pc_q      <= alt_pc_q[head_q];
      end else begin
        if (wb_en) begin
          ready_q[bus.wb_rob_id] <= 1'b1;
        end
        if (alloc) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          tail_q          <= tail_q + PTR_ONE;
        end
        if (retire) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + PTR_ONE;
          commit_reg_id_q <= reg_id_q[head_q];
          commit_data_q   <= data_q[head_q];
          commit_rob_id_q <= head_q;
        end else begin
          commit_reg_id_q <= '0;
        end
        case ({alloc, retire})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Payload needs no reset: it is only observed behind the valid/ready bits.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !do_flush) begin
      if (alloc) begin
        reg_id_q[tail_q]     <= bus.issue_reg_id;
        is_branch_q[tail_q]  <= bus.issue_is_branch;
        alt_pc_q[tail_q]     <= bus.issue_alt_pc;
        mispredict_q[tail_q] <= 1'b0;
      end
      if (wb_en) begin
        data_q[bus.wb_rob_id]       <= bus.wb_data;
        mispredict_q[bus.wb_rob_id] <= bus.wb_mispredict;
      end
    end
  end

  always_comb begin
    bus.rob_ready_j = valid_q[bus.rob_rob_id_j] && ready_q[bus.rob_rob_id_j];
    bus.rob_data_j  = data_q[bus.rob_rob_id_j];
    bus.rob_ready_k = valid_q[bus.rob_rob_id_k] && ready_q[bus.rob_rob_id_k];
    bus.rob_data_k  = data_q[bus.rob_rob_id_k];
`ifdef ROB_BYPASS_EN
    if (bus.wb_valid && (bus.wb_rob_id == bus.rob_rob_id_j) && valid_q[bus.rob_rob_id_j]) begin
      bus.rob_ready_j = 1'b1;
      bus.rob_data_j  = bus.wb_data;
    end
    if (bus.wb_valid && (bus.wb_rob_id == bus.rob_rob_id_k) && valid_q[bus.rob_rob_id_k]) begin
      bus.rob_ready_k = 1'b1;
      bus.rob_data_k  = bus.wb_data;
    end
`endif
  end

  assign bus.issue_rob_id  = tail_q;
  assign bus.full          = full;
  assign bus.commit_reg_id = commit_reg_id_q;
  assign bus.commit_data   = commit_data_q;
  assign bus.commit_rob_id = commit_rob_id_q;
  assign bus.flush         = flush_q;
  assign bus.flush_pc      = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer against a queue-based model
module tb_reorder_buffer;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  always #5 clk_in = ~clk_in;

  reorder_buffer_if #(.ROB_WIDTH(3), .REG_WIDTH(5)) bus ();

  reorder_buffer #(.ROB_WIDTH(3), .REG_WIDTH(5)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  typedef struct {
    bit          iv;
    logic [4:0]  ireg;
    bit          ibr;
    logic [31:0] ialt;
    bit          wv;
    logic [2:0]  wid;
    logic [31:0] wdata;
    bit          wmis;
    logic [4:0]  e_creg;
    logic [2:0]  e_crob;
    logic [31:0] e_cdata;
    bit          e_flush;
    bit          e_full;
  } vec_t;

  typedef struct {
    logic [4:0]  reg_id;
    bit          rdy;
    logic [31:0] data;
    bit          br;
    bit          misp;
    logic [31:0] alt;
  } ment_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: program-ordered queue of live entries, oldest first.
  ment_t       mq[$];
  int          m_head;
  bit          m_flush;
  logic [31:0] m_fpc;
  logic [4:0]  m_creg;
  logic [31:0] m_cdata;
  int          m_crob;
  bit          m_cvalid;
  vec_t        cur;
  bit          cur_rdy;
  int          seen[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(bit iv, int ireg, bit ibr, int ialt, bit wv, int wid, int wdata, bit wmis,
                              int e_creg, int e_crob, int e_cdata, bit e_flush, bit e_full);
    vec_t v;
    v.iv = iv; v.ireg = 5'(ireg); v.ibr = ibr; v.ialt = 32'(ialt);
    v.wv = wv; v.wid = 3'(wid); v.wdata = 32'(wdata); v.wmis = wmis;
    v.e_creg = 5'(e_creg); v.e_crob = 3'(e_crob); v.e_cdata = 32'(e_cdata);
    v.e_flush = e_flush; v.e_full = e_full;
    return v;
  endfunction

  function automatic vec_t mk_iss(int r, bit br, int alt);
    return mk(1, r, br, alt, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t mk_wb(int id, int d, bit mis);
    return mk(0, 0, 0, 0, 1, id, d, mis, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t mk_idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_head = 0; m_flush = 0; m_fpc = '0;
    m_creg = '0; m_cdata = '0; m_crob = 0; m_cvalid = 1;
  endfunction

  function automatic int m_idx(int id);
    return (id - m_head + 8) % 8;
  endfunction

  function automatic void m_step();
    bit    ret;
    bit    was_full;
    ment_t h;
    int    idx;
    if (m_flush) begin
      m_flush = 0; m_creg = '0; m_cvalid = 0;
      return;
    end
    ret      = (mq.size() > 0) && mq[0].rdy;
    was_full = (mq.size() == 8);
    if (ret && mq[0].br && mq[0].misp) begin
      m_fpc = mq[0].alt;
      mq.delete();
      m_head = 0; m_flush = 1; m_creg = '0; m_cvalid = 0;
      return;
    end
    if (ret) h = mq[0];
    if (cur.wv) begin
      idx = m_idx(int'(cur.wid));
      if (idx < mq.size()) begin
        mq[idx].rdy  = 1;
        mq[idx].data = cur.wdata;
        mq[idx].misp = cur.wmis;
      end
    end
    if (ret) begin
      m_creg = h.reg_id; m_cdata = h.data; m_crob = m_head; m_cvalid = 1;
      void'(mq.pop_front());
      m_head = (m_head + 1) % 8;
    end else begin
      m_creg = '0; m_cvalid = 0;
    end
    if (cur.iv && !was_full) begin
      h.reg_id = cur.ireg; h.rdy = 0; h.data = '0; h.br = cur.ibr; h.misp = 0; h.alt = cur.ialt;
      mq.push_back(h);
    end
  endfunction

  task automatic check_query(input string name, input int id, input logic act_rdy, input logic [31:0] act_data);
    int          idx;
    bit          exp_rdy;
    logic [31:0] exp_data;
    idx      = m_idx(id);
    exp_rdy  = (idx < mq.size()) && mq[idx].rdy;
    exp_data = exp_rdy ? mq[idx].data : '0;
`ifdef ROB_BYPASS_EN
    if ((idx < mq.size()) && cur.wv && (int'(cur.wid) == id)) begin
      exp_rdy  = 1;
      exp_data = cur.wdata;
    end
`endif
    check({name, "_ready"}, 32'(act_rdy), 32'(exp_rdy));
    if (exp_rdy) check({name, "_data"}, act_data, exp_data);
  endtask

  task automatic drive(input vec_t v, input bit rdy, input int qj, input int qk);
    cur = v; cur_rdy = rdy;
    rdy_in              = rdy;
    bus.issue_valid     = v.iv;
    bus.issue_reg_id    = v.ireg;
    bus.issue_is_branch = v.ibr;
    bus.issue_alt_pc    = v.ialt;
    bus.wb_valid        = v.wv;
    bus.wb_rob_id       = v.wid;
    bus.wb_data         = v.wdata;
    bus.wb_mispredict   = v.wmis;
    bus.rob_rob_id_j    = 3'(qj);
    bus.rob_rob_id_k    = 3'(qk);
    #1;
    check("issue_rob_id", 32'(bus.issue_rob_id), 32'((m_head + mq.size()) % 8));
    check("full", 32'(bus.full), 32'(mq.size() == 8));
    check_query("query_j", qj, bus.rob_ready_j, bus.rob_data_j);
    check_query("query_k", qk, bus.rob_ready_k, bus.rob_data_k);
  endtask

  task automatic clock_edge();
    if (cur_rdy) m_step();
    @(posedge clk_in);
    #1;
    check("commit_reg_id", 32'(bus.commit_reg_id), 32'(m_creg));
    if (m_cvalid) begin
      check("commit_data", bus.commit_data, m_cdata);
      check("commit_rob_id", 32'(bus.commit_rob_id), 32'(m_crob));
    end
    check("flush", 32'(bus.flush), 32'(m_flush));
    if (m_flush) check("flush_pc", bus.flush_pc, m_fpc);
    if (bus.commit_reg_id != '0) seen.push_back(int'(bus.commit_rob_id));
  endtask

  task automatic apply(input vec_t v, input bit rdy);
    drive(v, rdy, $urandom_range(0, 7), $urandom_range(0, 7));
    clock_edge();
  endtask

  task automatic reset_check();
    rst_in = 1'b0;
    #1;
    check("rst commit_reg_id", 32'(bus.commit_reg_id), 32'h0);
    check("rst commit_data", bus.commit_data, 32'h0);
    check("rst commit_rob_id", 32'(bus.commit_rob_id), 32'h0);
    check("rst flush", 32'(bus.flush), 32'h0);
    check("rst flush_pc", bus.flush_pc, 32'h0);
    check("rst full", 32'(bus.full), 32'h0);
    check("rst issue_rob_id", 32'(bus.issue_rob_id), 32'h0);
    check("rst rob_ready_j", 32'(bus.rob_ready_j), 32'h0);
    m_reset();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[36];
    vec_t v;
    int   wb_order[8];
    int   exp_ids[11];
    bit   r;

    rst_in = 1'b1;
    cur = mk_idle();
    drive(mk_idle(), 1'b1, 0, 0);
    #1;
    reset_check();

    // Full/in-order drain, single entry round trip, then mispredict flush.
    for (int i = 0; i < 8; i++) vecs[i] = mk(1, i + 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i == 7);
    vecs[8] = mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) vecs[9 + k] = mk(0, 0, 0, 0, 1, 7 - k, 'h70 + 7 - k, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) vecs[17 + k] = mk(0, 0, 0, 0, 0, 0, 0, 0, k + 1, k, 'h70 + k, 0, 0);
    vecs[25] = mk_idle();
    vecs[26] = mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[27] = mk(0, 0, 0, 0, 1, 0, 'hAB, 0, 0, 0, 0, 0, 0);
    vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 'hAB, 0, 0);
    vecs[29] = mk_idle();
    vecs[30] = mk(1, 0, 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[31] = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[32] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    vecs[33] = mk(0, 0, 0, 0, 1, 2, 'h33, 0, 0, 0, 0, 1, 0);
    vecs[34] = mk(1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[35] = mk_idle();

    for (int i = 0; i < 36; i++) begin
      apply(vecs[i], 1'b1);
      check($sformatf("vec%0d commit_reg_id", i), 32'(bus.commit_reg_id), 32'(vecs[i].e_creg));
      if (vecs[i].e_creg != '0) begin
        check($sformatf("vec%0d commit_rob_id", i), 32'(bus.commit_rob_id), 32'(vecs[i].e_crob));
        check($sformatf("vec%0d commit_data", i), bus.commit_data, vecs[i].e_cdata);
      end
      check($sformatf("vec%0d flush", i), 32'(bus.flush), 32'(vecs[i].e_flush));
      if (vecs[i].e_flush) check($sformatf("vec%0d flush_pc", i), bus.flush_pc, 32'h100);
      check($sformatf("vec%0d full", i), 32'(bus.full), 32'(vecs[i].e_full));
    end

    // Wrap-around: fill, retire three, reuse ids 0..2, drain in order.
    seen.delete();
    for (int i = 0; i < 8; i++) apply(mk_iss(10 + i, 0, 0), 1'b1);
    for (int i = 0; i < 3; i++) apply(mk_wb(i, 'h200 + i, 0), 1'b1);
    apply(mk_idle(), 1'b1);
    for (int i = 0; i < 3; i++) apply(mk_iss(18 + i, 0, 0), 1'b1);
    wb_order = '{6, 0, 3, 2, 7, 5, 1, 4};
    for (int i = 0; i < 8; i++) apply(mk_wb(wb_order[i], 'h300 + i, 0), 1'b1);
    repeat (12) apply(mk_idle(), 1'b1);
    exp_ids = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    check("wrap commit count", 32'(seen.size()), 32'd11);
    for (int k = 0; k < 11 && k < seen.size(); k++)
      check($sformatf("wrap commit id %0d", k), 32'(seen[k]), 32'(exp_ids[k]));

    // Same-cycle query against writeback, then stored-state query.
    #3;
    reset_check();
    apply(mk_iss(21, 0, 0), 1'b1);
    apply(mk_iss(22, 0, 0), 1'b1);
    apply(mk_iss(23, 0, 0), 1'b1);
    drive(mk_wb(2, 'h55, 0), 1'b1, 2, 0);
`ifdef ROB_BYPASS_EN
    check("bypass ready_j", 32'(bus.rob_ready_j), 32'h1);
    check("bypass data_j", bus.rob_data_j, 32'h55);
`else
    check("no-bypass ready_j", 32'(bus.rob_ready_j), 32'h0);
`endif
    clock_edge();
    drive(mk_idle(), 1'b1, 2, 2);
    check("stored ready_j", 32'(bus.rob_ready_j), 32'h1);
    check("stored data_j", bus.rob_data_j, 32'h55);
    check("stored ready_k", 32'(bus.rob_ready_k), 32'h1);
    check("stored data_k", bus.rob_data_k, 32'h55);
    clock_edge();
    apply(mk_wb(0, 'h11, 0), 1'b1);
    apply(mk_idle(), 1'b1);

    // Stall: nothing moves while rdy_in is low, then async reset clears outputs.
    for (int s = 0; s < 3; s++) begin
      drive(mk(1, 9, 0, 0, 1, 1, 'h99, 0, 0, 0, 0, 0, 0), 1'b0, 1, 2);
      check("stall issue_rob_id", 32'(bus.issue_rob_id), 32'd3);
      check("stall ready_j", 32'(bus.rob_ready_j), 32'h0);
      clock_edge();
      check("stall commit_reg_id", 32'(bus.commit_reg_id), 32'd21);
      check("stall commit_data", bus.commit_data, 32'h11);
      check("stall commit_rob_id", 32'(bus.commit_rob_id), 32'd0);
    end
    #3;
    reset_check();

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      r       = ($urandom_range(0, 9) != 0);
      v       = mk_idle();
      v.iv    = 1'($urandom_range(0, 1));
      v.ibr   = ($urandom_range(0, 3) == 0);
      v.ireg  = v.ibr ? 5'd0 : 5'($urandom_range(0, 31));
      v.ialt  = $urandom;
      v.wv    = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0)
        v.wid = 3'((m_head + int'($urandom_range(0, mq.size() - 1))) % 8);
      else
        v.wid = 3'($urandom_range(0, 7));
      v.wdata = $urandom;
      v.wmis  = ($urandom_range(0, 3) == 0);
      apply(v, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
